// File: rtl/rob_core.sv
// Reorder buffer for the out-of-order RV32I core.
// Allocates ids at issue, collects CDB results, retires in program order,
// answers operand queries and raises a one-cycle flush when a mispredicted
// branch retires.
module rob_core #(
   parameter int ROB_SIZE_WIDTH = 4,
   parameter int ROB_DEPTH      = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      rdy,
   input  logic                      issue_valid,
   input  logic [4:0]                issue_in_rd,
   input  logic                      issue_is_branch,
   output logic                      rob_full,
   output logic [ROB_SIZE_WIDTH-1:0] issue_rob_id,
   output logic [4:0]                issue_rd,
   input  logic                      wb_valid,
   input  logic [ROB_SIZE_WIDTH-1:0] wb_rob_id,
   input  logic [31:0]               wb_value,
   input  logic                      wb_mispredict,
   input  logic [31:0]               wb_next_pc,
   input  logic [ROB_SIZE_WIDTH-1:0] ask_rob_id1,
   input  logic [ROB_SIZE_WIDTH-1:0] ask_rob_id2,
   output logic [31:0]               get_value1,
   output logic [31:0]               get_value2,
   output logic                      get_ready1,
   output logic                      get_ready2,
   output logic [ROB_SIZE_WIDTH-1:0] commit_rob_id,
   output logic [4:0]                commit_rd,
   output logic [31:0]               commit_value,
   output logic                      flush,
   output logic [31:0]               flush_pc
);

   localparam int IDX_W = (ROB_DEPTH > 1) ? $clog2(ROB_DEPTH) : 1;

   typedef logic [IDX_W-1:0]          idx_t;
   typedef logic [ROB_SIZE_WIDTH-1:0] id_t;

   // slot s carries id s+1; id 0 means "none"
   function automatic idx_t idx_next(input idx_t p);
      return (p == idx_t'(ROB_DEPTH - 1)) ? '0 : p + idx_t'(1);
   endfunction

   function automatic logic id_ok(input id_t id);
      return (id != '0) && (int'(id) <= ROB_DEPTH);
   endfunction

   function automatic idx_t id_slot(input id_t id);
      return idx_t'(id - id_t'(1));
   endfunction

   function automatic id_t slot_id(input idx_t p);
      return id_t'(p) + id_t'(1);
   endfunction

   logic [ROB_DEPTH-1:0] busy_q;
   logic [ROB_DEPTH-1:0] ready_q;
   logic [ROB_DEPTH-1:0] br_q;
   logic [ROB_DEPTH-1:0] misp_q;
   logic [4:0]           rd_q  [ROB_DEPTH];
   logic [31:0]          val_q [ROB_DEPTH];
   logic [31:0]          npc_q [ROB_DEPTH];

   idx_t head_q;
   idx_t tail_q;
   id_t  count_q;

   logic full;
   logic issue_acc;
   logic wb_ok;
   idx_t wb_slot;
   logic retire;
   logic retire_flush;
   idx_t q1_slot;
   idx_t q2_slot;

   // issue acceptance, writeback qualification and retire decision
   always_comb begin
      full         = (count_q == id_t'(ROB_DEPTH));
      rob_full     = full || !rdy;
      issue_acc    = issue_valid && !full && rdy && !flush;
      issue_rob_id = issue_acc ? slot_id(tail_q) : '0;
      issue_rd     = issue_acc ? issue_in_rd : '0;
      wb_slot      = id_slot(wb_rob_id);
      wb_ok        = wb_valid && !flush && id_ok(wb_rob_id) && busy_q[wb_slot];
      retire       = busy_q[head_q] && ready_q[head_q];
      retire_flush = retire && br_q[head_q] && misp_q[head_q];
   end

   // operand query 1: stored ready value first, then CDB bypass
   always_comb begin
      q1_slot    = id_slot(ask_rob_id1);
      get_ready1 = 1'b0;
      get_value1 = '0;
      if (id_ok(ask_rob_id1) && busy_q[q1_slot] && ready_q[q1_slot]) begin
         get_ready1 = 1'b1;
         get_value1 = val_q[q1_slot];
      end else if (wb_valid && (ask_rob_id1 != '0) && (wb_rob_id == ask_rob_id1)) begin
         get_ready1 = 1'b1;
         get_value1 = wb_value;
      end
   end

   // operand query 2: same priority as query 1
   always_comb begin
      q2_slot    = id_slot(ask_rob_id2);
      get_ready2 = 1'b0;
      get_value2 = '0;
      if (id_ok(ask_rob_id2) && busy_q[q2_slot] && ready_q[q2_slot]) begin
         get_ready2 = 1'b1;
         get_value2 = val_q[q2_slot];
      end else if (wb_valid && (ask_rob_id2 != '0) && (wb_rob_id == ask_rob_id2)) begin
         get_ready2 = 1'b1;
         get_value2 = wb_value;
      end
   end

   // pointers, occupancy, status bits and registered commit/flush outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         head_q        <= '0;
         tail_q        <= '0;
         count_q       <= '0;
         busy_q        <= '0;
         ready_q       <= '0;
         commit_rob_id <= '0;
         commit_rd     <= '0;
         commit_value  <= '0;
         flush         <= 1'b0;
         flush_pc      <= '0;
      end else if (!rdy) begin
         commit_rob_id <= '0;
         flush         <= 1'b0;
      end else begin
         commit_rob_id <= '0;
         flush         <= 1'b0;
         if (issue_acc) begin
            busy_q[tail_q]  <= 1'b1;
            ready_q[tail_q] <= 1'b0;
            tail_q          <= idx_next(tail_q);
         end
         if (wb_ok) begin
            ready_q[wb_slot] <= 1'b1;
         end
         // retire after writeback so clearing the head slot wins
         if (retire) begin
            commit_rob_id   <= slot_id(head_q);
            commit_rd       <= rd_q[head_q];
            commit_value    <= val_q[head_q];
            busy_q[head_q]  <= 1'b0;
            ready_q[head_q] <= 1'b0;
            head_q          <= idx_next(head_q);
         end
         count_q <= count_q + id_t'(issue_acc) - id_t'(retire);
         // a retiring mispredicted branch discards everything younger
         if (retire_flush) begin
            flush    <= 1'b1;
            flush_pc <= npc_q[head_q];
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            busy_q   <= '0;
            ready_q  <= '0;
         end
      end
   end

   // entry payload; only meaningful while the matching busy bit is set
   always_ff @(posedge clk) begin
      if (!rst && rdy) begin
         if (issue_acc) begin
            rd_q[tail_q]   <= issue_in_rd;
            br_q[tail_q]   <= issue_is_branch;
            misp_q[tail_q] <= 1'b0;
         end
         if (wb_ok) begin
            val_q[wb_slot]  <= wb_value;
            misp_q[wb_slot] <= wb_mispredict;
            npc_q[wb_slot]  <= wb_next_pc;
         end
      end
   end

endmodule

// File: tb/tb_rob_core.sv
// Bench for rob_core: directed scenarios plus random traffic against a
// program-order queue model, with commits checked through a scoreboard.
module tb_rob_core;

   logic        clk;
   logic        rst;
   logic        rdy;
   logic        issue_valid;
   logic [4:0]  issue_in_rd;
   logic        issue_is_branch;
   logic        rob_full;
   logic [3:0]  issue_rob_id;
   logic [4:0]  issue_rd;
   logic        wb_valid;
   logic [3:0]  wb_rob_id;
   logic [31:0] wb_value;
   logic        wb_mispredict;
   logic [31:0] wb_next_pc;
   logic [3:0]  ask_rob_id1;
   logic [3:0]  ask_rob_id2;
   logic [31:0] get_value1;
   logic [31:0] get_value2;
   logic        get_ready1;
   logic        get_ready2;
   logic [3:0]  commit_rob_id;
   logic [4:0]  commit_rd;
   logic [31:0] commit_value;
   logic        flush;
   logic [31:0] flush_pc;

   rob_core #(.ROB_SIZE_WIDTH(4), .ROB_DEPTH(8)) dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .issue_valid(issue_valid), .issue_in_rd(issue_in_rd),
      .issue_is_branch(issue_is_branch), .rob_full(rob_full),
      .issue_rob_id(issue_rob_id), .issue_rd(issue_rd),
      .wb_valid(wb_valid), .wb_rob_id(wb_rob_id), .wb_value(wb_value),
      .wb_mispredict(wb_mispredict), .wb_next_pc(wb_next_pc),
      .ask_rob_id1(ask_rob_id1), .ask_rob_id2(ask_rob_id2),
      .get_value1(get_value1), .get_value2(get_value2),
      .get_ready1(get_ready1), .get_ready2(get_ready2),
      .commit_rob_id(commit_rob_id), .commit_rd(commit_rd),
      .commit_value(commit_value), .flush(flush), .flush_pc(flush_pc)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int          due;
      int          id;
      int          rd;
      logic [31:0] val;
      bit          fl;
      logic [31:0] pc;
   } exp_t;

   exp_t        sb[$];
   int          prog[$];
   int          m_rd   [16];
   bit          m_rdy  [16];
   bit          m_br   [16];
   bit          m_misp [16];
   logic [31:0] m_val  [16];
   logic [31:0] m_npc  [16];
   int          m_next = 1;
   bit          m_flush = 0;

   function automatic bit in_prog(input int id);
      foreach (prog[i]) if (prog[i] == id) return 1'b1;
      return 1'b0;
   endfunction

   // stimulus for the next cycle
   bit          t_iv, t_br, t_wbv, t_misp, t_rdy, t_rst;
   int          t_rd, t_wbid, t_a1, t_a2;
   logic [31:0] t_wbval, t_npc;

   task automatic idle();
      t_iv = 0; t_br = 0; t_rd = 0; t_wbv = 0; t_wbid = 0; t_misp = 0;
      t_wbval = '0; t_npc = '0; t_a1 = 0; t_a2 = 0; t_rdy = 1; t_rst = 0;
   endtask

   task automatic query_exp(input int a, output bit r, output logic [31:0] v);
      r = 0;
      v = '0;
      if (a != 0 && in_prog(a) && m_rdy[a]) begin
         r = 1; v = m_val[a];
      end else if (a != 0 && t_wbv && t_wbid == a) begin
         r = 1; v = t_wbval;
      end
   endtask

   // drive one cycle, check combinational outputs, advance the model
   task automatic step(input int exp_id);
      bit          qr;
      logic [31:0] qv;
      bit          full, acc, ret;
      int          h;
      exp_t        e;
      @(negedge clk);
      rst             = t_rst;
      rdy             = t_rdy;
      issue_valid     = t_iv;
      issue_in_rd     = 5'(t_rd);
      issue_is_branch = t_br;
      wb_valid        = t_wbv;
      wb_rob_id       = 4'(t_wbid);
      wb_value        = t_wbval;
      wb_mispredict   = t_misp;
      wb_next_pc      = t_npc;
      ask_rob_id1     = 4'(t_a1);
      ask_rob_id2     = 4'(t_a2);
      #1;
      if (t_rst) begin
         prog.delete();
         m_next  = 1;
         m_flush = 0;
      end else begin
         query_exp(t_a1, qr, qv);
         chk("get_ready1", 32'(get_ready1), 32'(qr));
         chk("get_value1", get_value1, qv);
         query_exp(t_a2, qr, qv);
         chk("get_ready2", 32'(get_ready2), 32'(qr));
         chk("get_value2", get_value2, qv);
         if (!t_rdy) begin
            chk("rob_full_hold", 32'(rob_full), 32'd1);
            chk("issue_id_hold", 32'(issue_rob_id), 32'd0);
            m_flush = 0;
         end else begin
            full = (prog.size() == 8);
            acc  = t_iv && !full && !m_flush;
            chk("rob_full", 32'(rob_full), 32'(full));
            chk("issue_rob_id", 32'(issue_rob_id), acc ? 32'(m_next) : 32'd0);
            chk("issue_rd", 32'(issue_rd), acc ? 32'(t_rd) : 32'd0);
            ret = (prog.size() > 0) && m_rdy[prog[0]];
            if (ret) begin
               h     = prog[0];
               e.due = cyc + 1;
               e.id  = h;
               e.rd  = m_rd[h];
               e.val = m_val[h];
               e.fl  = m_br[h] && m_misp[h];
               e.pc  = m_npc[h];
               sb.push_back(e);
            end
            if (t_wbv && !m_flush && in_prog(t_wbid)) begin
               m_rdy[t_wbid]  = 1;
               m_val[t_wbid]  = t_wbval;
               m_misp[t_wbid] = t_misp;
               m_npc[t_wbid]  = t_npc;
            end
            if (acc) begin
               prog.push_back(m_next);
               m_rd[m_next]   = t_rd;
               m_br[m_next]   = t_br;
               m_rdy[m_next]  = 0;
               m_misp[m_next] = 0;
               m_next         = (m_next % 8) + 1;
            end
            m_flush = 0;
            if (ret) begin
               void'(prog.pop_front());
               if (e.fl) begin
                  prog.delete();
                  m_next  = 1;
                  m_flush = 1;
               end
            end
         end
      end
      if (exp_id >= 0) chk("issue_id_directed", 32'(issue_rob_id), 32'(exp_id));
   endtask

   // scoreboard monitor for registered commit/flush outputs
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (commit_rob_id != 0 || flush) begin
            if (sb.size() == 0) begin
               chk("commit_unexpected", 32'(commit_rob_id), 32'd0);
            end else begin
               e = sb.pop_front();
               chk("commit_cycle", 32'(cyc), 32'(e.due));
               chk("commit_rob_id", 32'(commit_rob_id), 32'(e.id));
               chk("commit_rd", 32'(commit_rd), 32'(e.rd));
               chk("commit_value", commit_value, e.val);
               chk("flush", 32'(flush), 32'(e.fl));
               if (e.fl) chk("flush_pc", flush_pc, e.pc);
            end
         end
         while (sb.size() > 0 && sb[0].due < cyc) begin
            chk("commit_missing", 32'(commit_rob_id), 32'(sb[0].id));
            void'(sb.pop_front());
         end
      end
   end

   task automatic chk_zero(input string tag);
      chk({tag, "_commit_id"}, 32'(commit_rob_id), 32'd0);
      chk({tag, "_commit_rd"}, 32'(commit_rd), 32'd0);
      chk({tag, "_commit_val"}, commit_value, 32'd0);
      chk({tag, "_flush"}, 32'(flush), 32'd0);
      chk({tag, "_flush_pc"}, flush_pc, 32'd0);
   endtask

   task automatic do_reset();
      idle(); t_rst = 1; step(-1);
      idle(); step(-1);
   endtask

   initial begin
      rst = 1; rdy = 0; issue_valid = 0; issue_in_rd = '0; issue_is_branch = 0;
      wb_valid = 0; wb_rob_id = '0; wb_value = '0; wb_mispredict = 0; wb_next_pc = '0;
      ask_rob_id1 = '0; ask_rob_id2 = '0;

      // reset and in-order issue
      do_reset();
      chk_zero("reset");
      chk("reset_rob_full", 32'(rob_full), 32'd0);
      idle(); t_iv = 1; t_rd = 5; step(1);
      idle(); t_iv = 1; t_rd = 6; step(2);
      idle(); t_iv = 1; t_rd = 0; step(3);
      chk("issue3_rd", 32'(issue_rd), 32'd0);

      // out-of-order writeback, in-order retire
      idle(); t_wbv = 1; t_wbid = 2; t_wbval = 32'h22; step(-1);
      idle(); t_wbv = 1; t_wbid = 1; t_wbval = 32'h11; step(-1);
      chk("no_early_commit", 32'(commit_rob_id), 32'd0);
      idle(); step(-1);
      idle(); step(-1);
      chk("first_commit_id", 32'(commit_rob_id), 32'd1);
      chk("first_commit_rd", 32'(commit_rd), 32'd5);
      chk("first_commit_val", commit_value, 32'h11);
      idle(); step(-1);
      chk("second_commit_id", 32'(commit_rob_id), 32'd2);
      chk("second_commit_val", commit_value, 32'h22);

      // fill to full, then retire while issue is held
      do_reset();
      for (int i = 1; i <= 8; i++) begin
         idle(); t_iv = 1; t_rd = i; step(i);
      end
      idle(); t_iv = 1; t_rd = 9; step(0);
      chk("full_flag", 32'(rob_full), 32'd1);
      idle(); t_iv = 1; t_rd = 9; t_wbv = 1; t_wbid = 1; t_wbval = 32'h1234; step(0);
      idle(); t_iv = 1; t_rd = 9; step(0);
      idle(); t_iv = 1; t_rd = 9; step(1);

      // CDB bypass on the query port
      idle(); t_wbv = 1; t_wbid = 4; t_wbval = 32'hABCD; t_a1 = 4; t_a2 = 5; step(-1);
      chk("bypass_ready1", 32'(get_ready1), 32'd1);
      chk("bypass_value1", get_value1, 32'hABCD);
      chk("unready_ready2", 32'(get_ready2), 32'd0);
      idle(); t_a1 = 4; step(-1);
      chk("stored_value1", get_value1, 32'hABCD);

      // mispredicted branch at retire
      do_reset();
      idle(); t_iv = 1; t_br = 1; t_rd = 0; step(1);
      idle(); t_iv = 1; t_rd = 7; step(2);
      idle(); t_iv = 1; t_rd = 8; step(3);
      idle(); t_wbv = 1; t_wbid = 2; t_wbval = 32'h2; step(-1);
      idle(); t_wbv = 1; t_wbid = 1; t_misp = 1; t_npc = 32'h100; step(-1);
      idle(); step(-1);
      idle(); t_iv = 1; t_rd = 3; t_wbv = 1; t_wbid = 3; t_wbval = 32'h3; step(0);
      chk("flush_high", 32'(flush), 32'd1);
      chk("flush_pc_val", flush_pc, 32'h100);
      chk("branch_commit", 32'(commit_rob_id), 32'd1);
      idle(); t_iv = 1; t_rd = 4; step(1);
      chk("flush_one_cycle", 32'(flush), 32'd0);
      idle(); t_wbv = 1; t_wbid = 3; t_wbval = 32'h33; step(-1);
      idle(); t_a1 = 3; step(-1);
      chk("late_wb_ignored", 32'(get_ready1), 32'd0);

      // rdy low holds a ready head
      idle(); t_wbv = 1; t_wbid = 1; t_wbval = 32'h55; step(-1);
      for (int i = 0; i < 3; i++) begin
         idle(); t_rdy = 0; t_iv = 1; step(0);
         chk("rdy_low_no_commit", 32'(commit_rob_id), 32'd0);
      end
      idle(); step(-1);
      idle(); step(-1);
      chk("rdy_resume_commit", 32'(commit_rob_id), 32'd1);
      chk("rdy_resume_val", commit_value, 32'h55);

      // reset in the middle of traffic
      idle(); t_iv = 1; t_rd = 12; step(-1);
      idle(); t_iv = 1; t_rd = 13; t_rst = 1; step(-1);
      idle(); step(-1);
      chk_zero("mid_reset");
      idle(); t_iv = 1; t_rd = 2; step(1);

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         idle();
         t_iv = ($urandom_range(0, 9) < 7);
         t_br = ($urandom_range(0, 4) == 0);
         t_rd = t_br ? 0 : int'($urandom_range(0, 31));
         if (prog.size() > 0 && $urandom_range(0, 2) != 0) begin
            t_wbv  = 1;
            t_wbid = prog[$urandom_range(0, prog.size() - 1)];
         end else begin
            t_wbv  = ($urandom_range(0, 4) == 0);
            t_wbid = int'($urandom_range(0, 9));
         end
         t_misp  = m_br[t_wbid] && ($urandom_range(0, 3) == 0);
         t_wbval = $urandom;
         t_npc   = $urandom;
         t_a1    = int'($urandom_range(0, 9));
         t_a2    = ($urandom_range(0, 1) == 0) ? t_wbid : int'($urandom_range(0, 9));
         t_rdy   = ($urandom_range(0, 9) != 0);
         t_rst   = ($urandom_range(0, 499) == 0);
         step(-1);
      end

      for (int i = 0; i < 3; i++) begin
         idle(); step(-1);
      end
      @(negedge clk);
      #1;
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
